biriscv_conv_issue_ctrl: RTL

//  Sequences the single convolution accelerator shared by issue lanes 0 and 1.

---
 rtl/biriscv_conv_issue_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/biriscv_conv_issue_ctrl.sv
// Issue-side sequencer for the shared convolution accelerator: takes one conv
// instruction from lane 0 or lane 1, runs the start/done handshake and returns rd writeback.
module biriscv_conv_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_W      = 11
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        lane0_valid_i,
    input  logic [31:0] lane0_instr_i,
    input  logic [31:0] lane0_ra_i,
    input  logic [31:0] lane0_rb_i,
    output logic        lane0_accept_o,

    input  logic        lane1_valid_i,
    input  logic [31:0] lane1_instr_i,
    input  logic [31:0] lane1_ra_i,
    input  logic [31:0] lane1_rb_i,
    output logic        lane1_accept_o,

    input  logic        squash_i,

    output logic        acc_start_o,
    input  logic        acc_ready_i,
    output logic [31:0] acc_opcode_o,
    output logic [31:0] acc_a_o,
    output logic [31:0] acc_b_o,
    input  logic        acc_done_i,
    input  logic [31:0] acc_result_i,

    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_value_o,
    output logic        wb_error_o,
    input  logic        wb_accept_i,

    output logic        busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BUSY,
        ST_WB,
        ST_DRAIN
    } state_t;

    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t               state_q;
    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] cnt_d;
    logic [31:0]          opcode_q;
    logic [31:0]          op_a_q;
    logic [31:0]          op_b_q;
    logic [31:0]          result_q;
    logic                 acc_start_q;
    logic                 wb_valid_q;
    logic                 wb_error_q;
    logic                 busy_q;
    logic                 take0;
    logic                 take1;
    logic                 timed_out;

    assign cnt_d     = cnt_q + TIMEOUT_W'(1);
    assign timed_out = (cnt_q >= CNT_LAST);

    // Lane 0 is the older instruction, so it wins when both lanes offer at once.
    always_comb begin
        take0 = 1'b0;
        take1 = 1'b0;
        if (rst_i && (state_q == ST_IDLE) && !squash_i) begin
            if (lane0_valid_i) begin
                take0 = 1'b1;
            end else if (lane1_valid_i) begin
                take1 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            opcode_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            result_q    <= '0;
            acc_start_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_error_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (take0 || take1) begin
                        opcode_q    <= take0 ? lane0_instr_i : lane1_instr_i;
                        op_a_q      <= take0 ? lane0_ra_i    : lane1_ra_i;
                        op_b_q      <= take0 ? lane0_rb_i    : lane1_rb_i;
                        acc_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_START;
                    end
                end

                // Once ready is seen the accelerator owns the op and must be drained on squash.
                ST_START: begin
                    if (acc_ready_i) begin
                        acc_start_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= squash_i ? ST_DRAIN : ST_BUSY;
                    end else if (squash_i) begin
                        acc_start_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end

                ST_BUSY: begin
                    cnt_q <= cnt_d;
                    if (acc_done_i && squash_i) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (acc_done_i) begin
                        result_q   <= acc_result_i;
                        wb_error_q <= 1'b0;
                        wb_valid_q <= 1'b1;
                        state_q    <= ST_WB;
                    end else if (squash_i) begin
                        state_q <= ST_DRAIN;
                    end else if (timed_out) begin
                        result_q   <= '0;
                        wb_error_q <= 1'b1;
                        wb_valid_q <= 1'b1;
                        state_q    <= ST_WB;
                    end
                end

                ST_WB: begin
                    if (wb_accept_i || squash_i) begin
                        wb_valid_q <= 1'b0;
                        wb_error_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end

                // The counter keeps running from BUSY so a lost done still frees the unit.
                ST_DRAIN: begin
                    cnt_q <= cnt_d;
                    if (acc_done_i || timed_out) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    acc_start_q <= 1'b0;
                    wb_valid_q  <= 1'b0;
                    wb_error_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign lane0_accept_o = take0;
    assign lane1_accept_o = take1;
    assign acc_start_o    = acc_start_q;
    assign acc_opcode_o   = opcode_q;
    assign acc_a_o        = op_a_q;
    assign acc_b_o        = op_b_q;
    assign wb_valid_o     = wb_valid_q;
    assign wb_rd_o        = opcode_q[11:7];
    assign wb_value_o     = result_q;
    assign wb_error_o     = wb_error_q;
    assign busy_o         = busy_q;

endmodule
